// File: rtl/enigma_controller.sv
// enigma_controller: three-rotor letter substitution engine.
// Each accepted character walks IDLE -> STEP -> CALC -> DONE -> IDLE.
// Letters step the rotors and are shifted by the rotor sum mod 26.
// All other characters pass through unchanged.
// Optional feature macro: ENIGMA_DOUBLE_STEP_EN (notch double-step on rotor 1).
//
// state | meaning
// IDLE  | waiting; accepts a character or a rotor load
// STEP  | advance rotors (letters only)
// CALC  | register the substituted character
// DONE  | letter_valid pulse, then back to IDLE
module enigma_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic        encrypt,
  input  logic [14:0] init_pos,
  input  logic        load,
  output logic [6:0]  letter_out,
  output logic        letter_valid,
  output logic [14:0] rotor_pos,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, STEP, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [6:0]  char_q, char_d;
  logic        enc_q, enc_d;
  logic [4:0]  r0_q, r0_d;
  logic [4:0]  r1_q, r1_d;
  logic [4:0]  r2_q, r2_d;
  logic [6:0]  letter_q, letter_d;

  logic        transfer;
  logic        is_letter;
  logic        carry0, carry1, dbl;
  logic [4:0]  r0_step, r1_step, r2_step;
  logic [4:0]  r1_sum, r2_sum;
  logic [1:0]  r1_adv, r2_adv;
  logic [6:0]  rot_sum, off, idx, enc_sum, enc_res, dec_res, sub_res;

  // Out-of-range load fields (26..31) load as position 0.
  function automatic logic [4:0] clamp_pos(input logic [4:0] f);
    return (f > 5'd25) ? 5'd0 : f;
  endfunction

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      char_q   <= 7'd0;
      enc_q    <= 1'b0;
      r0_q     <= 5'd0;
      r1_q     <= 5'd0;
      r2_q     <= 5'd0;
      letter_q <= 7'd0;
    end else begin
      state_q  <= state_d;
      char_q   <= char_d;
      enc_q    <= enc_d;
      r0_q     <= r0_d;
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      letter_q <= letter_d;
    end
  end

  // Next-state: a load in IDLE takes priority over an offered character.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (transfer) state_d = STEP;
      STEP:    state_d = CALC;
      CALC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Rotor stepping: odometer carries, plus the optional notch double-step.
  always_comb begin
    carry0  = (r0_q == 5'd25);
    r0_step = carry0 ? 5'd0 : r0_q + 5'd1;
`ifdef ENIGMA_DOUBLE_STEP_EN
    dbl     = (r1_q == 5'd24);
`else
    dbl     = 1'b0;
`endif
    // Rotors never exceed 25, so +2 still fits in 5 bits before the wrap.
    r1_adv  = {1'b0, carry0} + {1'b0, dbl};
    r1_sum  = r1_q + {3'b000, r1_adv};
    carry1  = (r1_sum >= 5'd26);
    r1_step = carry1 ? r1_sum - 5'd26 : r1_sum;
    r2_adv  = {1'b0, carry1} + {1'b0, dbl};
    r2_sum  = r2_q + {3'b000, r2_adv};
    r2_step = (r2_sum >= 5'd26) ? r2_sum - 5'd26 : r2_sum;
  end

  // Substitution: offset is the post-step rotor sum mod 26 (max sum 75).
  always_comb begin
    rot_sum = {2'b00, r0_q} + {2'b00, r1_q} + {2'b00, r2_q};
    if (rot_sum >= 7'd52)      off = rot_sum - 7'd52;
    else if (rot_sum >= 7'd26) off = rot_sum - 7'd26;
    else                       off = rot_sum;
    // For 'A'..'Z' (65..90) the letter index is the low five bits minus one.
    idx     = {2'b00, char_q[4:0] - 5'd1};
    enc_sum = idx + off;
    enc_res = (enc_sum >= 7'd26) ? enc_sum - 7'd26 : enc_sum;
    dec_res = (idx >= off) ? idx - off : idx + 7'd26 - off;
    sub_res = enc_q ? enc_res : dec_res;
  end

  // Datapath next values: capture, load, step and result registration.
  always_comb begin
    is_letter = (char_q >= 7'd65) && (char_q <= 7'd90);
    char_d    = char_q;
    enc_d     = enc_q;
    r0_d      = r0_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    letter_d  = letter_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          r0_d = clamp_pos(init_pos[4:0]);
          r1_d = clamp_pos(init_pos[9:5]);
          r2_d = clamp_pos(init_pos[14:10]);
        end else if (transfer) begin
          char_d = char_in;
          enc_d  = encrypt;
        end
      end
      STEP: begin
        if (is_letter) begin
          r0_d = r0_step;
          r1_d = r1_step;
          r2_d = r2_step;
        end
      end
      CALC: letter_d = is_letter ? 7'd65 + sub_res : char_q;
      default: ;
    endcase
  end

  // Outputs decoded from state and registered datapath.
  always_comb begin
    char_ready   = (state_q == IDLE) && !load && !reset;
    transfer     = char_valid && char_ready;
    busy         = (state_q != IDLE);
    letter_valid = (state_q == DONE);
    letter_out   = letter_q;
    rotor_pos    = {r2_q, r1_q, r0_q};
  end

endmodule

// File: tb/tb_enigma_controller.sv
// Scoreboard bench for enigma_controller: expected letter/rotor values are
// queued at each transfer and popped when letter_valid pulses.
module tb_enigma_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic        encrypt;
  logic [14:0] init_pos;
  logic        load;
  logic [6:0]  letter_out;
  logic        letter_valid;
  logic [14:0] rotor_pos;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_vld = 0;

  typedef struct {
    logic [6:0]  ch;
    logic [14:0] rot;
    int          c0;
  } exp_t;
  exp_t sb[$];

  enigma_controller dut (
    .clk          (clk),
    .reset        (reset),
    .char_in      (char_in),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .encrypt      (encrypt),
    .init_pos     (init_pos),
    .load         (load),
    .letter_out   (letter_out),
    .letter_valid (letter_valid),
    .rotor_pos    (rotor_pos),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] pk(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    return {c, b, a};
  endfunction

  // Output monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (letter_valid === 1'b1) begin
      n_vld++;
      if (sb.size() == 0) begin
        check_val("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("letter_out", {25'd0, letter_out}, {25'd0, e.ch});
        check_val("rotor_pos", {17'd0, rotor_pos}, {17'd0, e.rot});
        check_val("valid_latency", cyc - e.c0, 32'd3);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    char_valid = 1'b1;
    char_in = 7'd65;
    #1 check_val("ready_in_reset", {31'd0, char_ready}, 32'd0);
    @(negedge clk);
    #1;
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_valid", {31'd0, letter_valid}, 32'd0);
    check_val("rst_rot", {17'd0, rotor_pos}, 32'd0);
    check_val("rst_out", {25'd0, letter_out}, 32'd0);
    reset = 1'b0;
    char_valid = 1'b0;
    @(negedge clk);
    #1 check_val("ready_after_rst", {31'd0, char_ready}, 32'd1);
  endtask

  task automatic do_load(input logic [14:0] raw, input logic [14:0] exp_rot, input logic with_char);
    @(negedge clk);
    load = 1'b1;
    init_pos = raw;
    char_valid = with_char;
    char_in = 7'd81;
    #1 check_val("ready_during_load", {31'd0, char_ready}, 32'd0);
    @(negedge clk);
    load = 1'b0;
    char_valid = 1'b0;
    #1;
    check_val("load_rot", {17'd0, rotor_pos}, {17'd0, exp_rot});
    check_val("load_no_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic send_char(input logic [6:0] c, input logic enc, input logic [6:0] exp_ch,
                           input logic [14:0] exp_rot, input logic load_in_step);
    exp_t e;
    int   c0;
    bit   done;
    @(negedge clk);
    char_in = c;
    encrypt = enc;
    char_valid = 1'b1;
    load = 1'b0;
    #1 check_val("ready_idle", {31'd0, char_ready}, 32'd1);
    c0 = cyc;
    @(posedge clk);
    e.ch = exp_ch;
    e.rot = exp_rot;
    e.c0 = c0;
    sb.push_back(e);
    @(negedge clk);
    char_valid = 1'b0;
    char_in = 7'd85;
    encrypt = ~enc;
    check_val("busy_step", {31'd0, busy}, 32'd1);
    if (load_in_step) begin
      load = 1'b1;
      init_pos = pk(5'd7, 5'd8, 5'd9);
      #1 check_val("ready_busy", {31'd0, char_ready}, 32'd0);
    end
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      load = 1'b0;
      #1;
      if (sb.size() == 0) done = 1'b1;
    end
    check_val("sb_drained", {31'd0, done}, 32'd1);
    if (!done) sb.delete();
    @(negedge clk);
    #1;
    check_val("valid_width", {31'd0, letter_valid}, 32'd0);
    check_val("busy_idle", {31'd0, busy}, 32'd0);
    check_val("rot_after", {17'd0, rotor_pos}, {17'd0, exp_rot});
    check_val("out_hold", {25'd0, letter_out}, {25'd0, exp_ch});
  endtask

  task automatic reset_in_calc();
    int v0;
    v0 = n_vld;
    @(negedge clk);
    char_in = 7'd65;
    encrypt = 1'b1;
    char_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_valid", {31'd0, letter_valid}, 32'd0);
    check_val("abort_rot", {17'd0, rotor_pos}, 32'd0);
    check_val("abort_out", {25'd0, letter_out}, 32'd0);
    check_val("abort_ready_rst", {31'd0, char_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    #1 check_val("abort_ready_after", {31'd0, char_ready}, 32'd1);
    repeat (4) @(negedge clk);
    #1 check_val("abort_no_pulse", n_vld - v0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    char_in = 7'd0;
    char_valid = 1'b0;
    encrypt = 1'b0;
    init_pos = 15'd0;
    load = 1'b0;

    do_reset();
    send_char(7'd65, 1'b1, 7'd66, pk(5'd1, 5'd0, 5'd0), 1'b0);

    do_load(pk(5'd25, 5'd25, 5'd25), pk(5'd25, 5'd25, 5'd25), 1'b1);
    send_char(7'd90, 1'b1, 7'd90, pk(5'd0, 5'd0, 5'd0), 1'b0);

    do_load(pk(5'd27, 5'd5, 5'd30), pk(5'd0, 5'd5, 5'd0), 1'b0);

    do_load(pk(5'd2, 5'd0, 5'd0), pk(5'd2, 5'd0, 5'd0), 1'b0);
    send_char(7'd65, 1'b0, 7'd88, pk(5'd3, 5'd0, 5'd0), 1'b0);
    send_char(7'd33, 1'b1, 7'd33, pk(5'd3, 5'd0, 5'd0), 1'b1);
    send_char(7'd64, 1'b1, 7'd64, pk(5'd3, 5'd0, 5'd0), 1'b0);
    send_char(7'd91, 1'b0, 7'd91, pk(5'd3, 5'd0, 5'd0), 1'b0);

    do_load(pk(5'd25, 5'd3, 5'd0), pk(5'd25, 5'd3, 5'd0), 1'b0);
    send_char(7'd67, 1'b1, 7'd71, pk(5'd0, 5'd4, 5'd0), 1'b0);

    do_load(pk(5'd25, 5'd25, 5'd0), pk(5'd25, 5'd25, 5'd0), 1'b0);
    send_char(7'd97, 1'b1, 7'd97, pk(5'd25, 5'd25, 5'd0), 1'b0);
    send_char(7'd89, 1'b0, 7'd88, pk(5'd0, 5'd0, 5'd1), 1'b0);

    do_load(pk(5'd10, 5'd0, 5'd0), pk(5'd10, 5'd0, 5'd0), 1'b0);
    send_char(7'd90, 1'b1, 7'd75, pk(5'd11, 5'd0, 5'd0), 1'b0);

    do_load(pk(5'd20, 5'd20, 5'd20), pk(5'd20, 5'd20, 5'd20), 1'b0);
    send_char(7'd66, 1'b0, 7'd83, pk(5'd21, 5'd20, 5'd20), 1'b0);
    send_char(7'd66, 1'b1, 7'd76, pk(5'd22, 5'd20, 5'd20), 1'b0);

    do_load(pk(5'd0, 5'd24, 5'd0), pk(5'd0, 5'd24, 5'd0), 1'b0);
`ifdef ENIGMA_DOUBLE_STEP_EN
    send_char(7'd65, 1'b1, 7'd66, pk(5'd1, 5'd25, 5'd1), 1'b0);
`else
    send_char(7'd65, 1'b1, 7'd90, pk(5'd1, 5'd24, 5'd0), 1'b0);
`endif

    reset_in_calc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
